// File: rtl/prog_uart_loader.sv
// prog_uart_loader: UART bootloader that streams a length-prefixed word image into program RAM
// while holding the processor in reset.
module prog_uart_loader #(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_W         = 17,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_rx_i,
    output logic              prog_we_o,
    output logic [ADDR_W-1:0] prog_addr_o,
    output logic [31:0]       prog_wdata_o,
    output logic              system_reset_o,
    output logic              prog_mode_led_o,
    output logic              prog_err_o
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0] TO_M1 = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
    localparam logic [1:0] IDLE = 2'd0, LEN = 2'd1, DATA = 2'd2, DONE = 2'd3;

    logic [1:0]        sync_q, sync_d;
    logic              rx_prev_q, rx_prev_d;
    logic [1:0]        rx_st_q, rx_st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              rx, byte_valid, frame_err;
    logic [1:0]        state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       word_q, word_d;
    logic [31:0]       len_q, len_d, asm;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [3:0]        done_q, done_d;
    logic              we_q, we_d, err_q, err_d, sysrst_q, sysrst_d, led_q, led_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    assign rx = sync_q[1];
    assign sync_d = {sync_q[0], prog_rx_i};
    assign rx_prev_d = rx;

    always_comb begin
        rx_st_d = rx_st_q;
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
        sh_d = sh_q;
        byte_valid = 1'b0;
        frame_err = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx) rx_st_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_M1) begin
                cnt_d = '0;
                bit_d = '0;
                rx_st_d = rx ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL_M1) begin
                cnt_d = '0;
                sh_d = {rx, sh_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: if (cnt_q == FULL_M1) begin
                byte_valid = rx;
                frame_err = !rx;
                rx_st_d = RX_IDLE;
            end
        endcase
    end

    // Bytes shift in from the top, so after four bytes the first one sits in bits [7:0].
    assign asm = {sh_q, word_q};

    always_comb begin
        state_d = state_q;
        bcnt_d = bcnt_q;
        word_d = word_q;
        len_d = len_q;
        addr_d = addr_q;
        to_d = '0;
        done_d = '0;
        we_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d = 1'b0;
        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (byte_valid && sh_q == 8'hA5) state_d = LEN;
            end
            LEN, DATA: begin
                to_d = to_q + 1'b1;
                if (frame_err || (!byte_valid && to_q == TO_M1)) begin
                    err_d = 1'b1;
                    state_d = IDLE;
                end else if (byte_valid) begin
                    to_d = '0;
                    word_d = asm[31:8];
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 2'd3 && state_q == LEN) begin
                        len_d = asm;
                        addr_d = '0;
                        if (asm == '0) state_d = DONE;
                        else if ({1'b0, asm} > MAX_WORDS) begin
                            err_d = 1'b1;
                            state_d = IDLE;
                        end else state_d = DATA;
                    end else if (bcnt_q == 2'd3) begin
                        we_d = 1'b1;
                        waddr_d = addr_q[ADDR_W-1:0];
                        wdata_d = asm;
                        addr_d = addr_q + 1'b1;
                        if (32'(addr_q) + 32'd1 == len_q) state_d = DONE;
                    end
                end
            end
            default: begin
                done_d = done_q + 1'b1;
                if (done_q == 4'd15) state_d = IDLE;
            end
        endcase
    end

    assign sysrst_d = (state_d == IDLE);
    assign led_d = (state_d != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
            rx_st_q <= RX_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            state_q <= IDLE;
            bcnt_q <= '0;
            word_q <= '0;
            len_q <= '0;
            addr_q <= '0;
            to_q <= '0;
            done_q <= '0;
            we_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q <= 1'b0;
            sysrst_q <= 1'b1;
            led_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rx_prev_q <= rx_prev_d;
            rx_st_q <= rx_st_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            state_q <= state_d;
            bcnt_q <= bcnt_d;
            word_q <= word_d;
            len_q <= len_d;
            addr_q <= addr_d;
            to_q <= to_d;
            done_q <= done_d;
            we_q <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q <= err_d;
            sysrst_q <= sysrst_d;
            led_q <= led_d;
        end
    end

    assign prog_we_o = we_q;
    assign prog_addr_o = waddr_q;
    assign prog_wdata_o = wdata_q;
    assign prog_err_o = err_q;
    assign system_reset_o = sysrst_q;
    assign prog_mode_led_o = led_q;
endmodule

// File: tb/tb_prog_uart_loader.sv
// tb_prog_uart_loader: drives UART load streams and checks RAM writes, reset window and error pulses
// against a byte-stream reference model.
module tb_prog_uart_loader;
    localparam int CPB = 10;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          we, sysrst, led, err;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            checks = 0, passed = 0;
    int            cyc = 0, err_cnt = 0, fall_cyc = -1, rise_cyc = -1, last_we_cyc = -1;
    logic          we_double = 1'b0, prev_we = 1'b0, prev_sr = 1'b1;
    logic [AW-1:0] got_addr[$], exp_addr[$];
    logic [31:0]   got_data[$], exp_data[$];

    always #5 clk = ~clk;

    prog_uart_loader #(.CLK_FREQ(1000000), .BAUD(100000), .ADDR_W(AW), .TIMEOUT_CYCLES(500)) dut (
        .clk_i(clk), .rst_ni(rst_n), .prog_rx_i(rx), .prog_we_o(we), .prog_addr_o(addr),
        .prog_wdata_o(wdata), .system_reset_o(sysrst), .prog_mode_led_o(led), .prog_err_o(err)
    );

    always @(negedge clk) begin
        cyc++;
        if (we) begin
            got_addr.push_back(addr);
            got_data.push_back(wdata);
            last_we_cyc = cyc;
            if (prev_we) we_double = 1'b1;
        end
        if (err) err_cnt++;
        if (prev_sr && !sysrst) fall_cyc = cyc;
        if (!prev_sr && sysrst) rise_cyc = cyc;
        prev_we = we;
        prev_sr = sysrst;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_seq(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i], 1'b1);
    endtask

    // Reference: first 0xA5 opens a load, next four bytes are N (LE), then N LE words to addresses 0..N-1.
    task automatic model(input logic [7:0] bs[$]);
        int i, n;
        exp_addr.delete();
        exp_data.delete();
        i = 0;
        while (i < bs.size() && bs[i] != 8'hA5) i++;
        n = int'({bs[i+4], bs[i+3], bs[i+2], bs[i+1]});
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(AW'(w));
            exp_data.push_back({bs[i+4*w+8], bs[i+4*w+7], bs[i+4*w+6], bs[i+4*w+5]});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({we, addr, wdata, err, sysrst, led} !== {1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_values got we=%b addr=%h data=%h err=%b sr=%b led=%b", we, addr, wdata, err, sysrst, led);
        else passed++;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({sysrst, led, err_cnt} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL idle_after_reset got sr=%b led=%b errs=%0d exp sr=1 led=0 errs=0", sysrst, led, err_cnt);
        else passed++;
    endtask

    task automatic test_two_words;
        logic [7:0] s[$];
        int n0, e0;
        n0 = got_addr.size();
        e0 = err_cnt;
        s = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model(s);
        send_byte(s[0], 1'b1);
        checks++;
        if ({sysrst, led} !== 2'b01) $display("FAIL two_words_prog_mode got sr=%b led=%b exp sr=0 led=1", sysrst, led);
        else passed++;
        send_seq(s[1:$]);
        repeat (40) @(negedge clk);
        checks++;
        if (got_addr.size() - n0 !== exp_addr.size())
            $display("FAIL two_words_count got %0d exp %0d", got_addr.size() - n0, exp_addr.size());
        else passed++;
        for (int k = 0; k < exp_addr.size() && n0 + k < got_addr.size(); k++) begin
            checks++;
            if (got_addr[n0+k] !== exp_addr[k] || got_data[n0+k] !== exp_data[k])
                $display("FAIL two_words_write%0d got %h/%h exp %h/%h", k, got_addr[n0+k], got_data[n0+k], exp_addr[k], exp_data[k]);
            else passed++;
        end
        checks++;
        if (rise_cyc - last_we_cyc !== 16) $display("FAIL two_words_done_len got %0d exp 16", rise_cyc - last_we_cyc);
        else passed++;
        checks++;
        if (rise_cyc - fall_cyc !== 1216) $display("FAIL two_words_reset_window got %0d exp 1216", rise_cyc - fall_cyc);
        else passed++;
        checks++;
        if (err_cnt - e0 !== 0) $display("FAIL two_words_err got %0d exp 0", err_cnt - e0);
        else passed++;
    endtask

    task automatic test_len_zero;
        logic [7:0] s[$];
        int n0, e0;
        n0 = got_addr.size();
        e0 = err_cnt;
        s = '{8'h55, 8'h00};
        send_seq(s);
        checks++;
        if (sysrst !== 1'b1) $display("FAIL len_zero_ignored got sr=%b exp 1", sysrst);
        else passed++;
        s = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(s);
        repeat (40) @(negedge clk);
        checks++;
        if (got_addr.size() - n0 !== 0 || err_cnt - e0 !== 0)
            $display("FAIL len_zero_writes got writes=%0d errs=%0d exp 0/0", got_addr.size() - n0, err_cnt - e0);
        else passed++;
        checks++;
        if (rise_cyc - fall_cyc !== 416) $display("FAIL len_zero_window got %0d exp 416", rise_cyc - fall_cyc);
        else passed++;
    endtask

    task automatic test_timeout;
        logic [7:0] s[$];
        int n0, e0;
        n0 = got_addr.size();
        e0 = err_cnt;
        s = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        send_seq(s);
        checks++;
        if (led !== 1'b1) $display("FAIL timeout_before got led=%b exp 1", led);
        else passed++;
        repeat (600) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || got_addr.size() - n0 !== 0 || {sysrst, led} !== 2'b10)
            $display("FAIL timeout got errs=%0d writes=%0d sr=%b led=%b exp 1/0/1/0", err_cnt - e0, got_addr.size() - n0, sysrst, led);
        else passed++;
    endtask

    task automatic test_framing;
        logic [7:0] s[$];
        int n0, e0;
        n0 = got_addr.size();
        e0 = err_cnt;
        s = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
        send_seq(s);
        send_byte(8'h3C, 1'b0);
        repeat (30) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || got_addr.size() - n0 !== 0 || sysrst !== 1'b1)
            $display("FAIL framing got errs=%0d writes=%0d sr=%b exp 1/0/1", err_cnt - e0, got_addr.size() - n0, sysrst);
        else passed++;
        e0 = err_cnt;
        s = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hC3, 8'hA5, 8'h5A, 8'h3C};
        model(s);
        send_byte(8'hA5, 1'b1);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        send_seq(s[1:$]);
        repeat (40) @(negedge clk);
        checks++;
        if (got_addr.size() - n0 !== 1 || err_cnt - e0 !== 0)
            $display("FAIL glitch_count got writes=%0d errs=%0d exp 1/0", got_addr.size() - n0, err_cnt - e0);
        else passed++;
        checks++;
        if (got_addr.size() <= n0 || got_addr[n0] !== exp_addr[0] || got_data[n0] !== exp_data[0])
            $display("FAIL glitch_write got %h/%h exp %h/%h", got_addr[$], got_data[$], exp_addr[0], exp_data[0]);
        else passed++;
    endtask

    task automatic test_len_limit;
        logic [7:0] s[$];
        int n0, e0;
        n0 = got_addr.size();
        e0 = err_cnt;
        s = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00};
        send_seq(s);
        repeat (30) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || got_addr.size() - n0 !== 0 || {sysrst, led} !== 2'b10)
            $display("FAIL len_limit got errs=%0d writes=%0d sr=%b led=%b exp 1/0/1/0", err_cnt - e0, got_addr.size() - n0, sysrst, led);
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] s[$];
        int n0, e0;
        n0 = got_addr.size();
        e0 = err_cnt;
        s = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56};
        send_seq(s);
        checks++;
        if (err_cnt - e0 !== 0 || led !== 1'b1) $display("FAIL len_max_accept got errs=%0d led=%b exp 0/1", err_cnt - e0, led);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({we, addr, wdata, err, sysrst, led} !== {1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b1, 1'b0})
            $display("FAIL async_reset got we=%b addr=%h data=%h err=%b sr=%b led=%b", we, addr, wdata, err, sysrst, led);
        else passed++;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        s = '{8'h34, 8'h12, 8'hEF, 8'hBE};
        send_seq(s);
        repeat (40) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 0 || got_addr.size() - n0 !== 0 || sysrst !== 1'b1)
            $display("FAIL reset_mid_after got errs=%0d writes=%0d sr=%b exp 0/0/1", err_cnt - e0, got_addr.size() - n0, sysrst);
        else passed++;
    endtask

    task automatic test_random;
        logic [7:0] s[$];
        logic [7:0] b;
        int n, n0, e0;
        for (int it = 0; it < 6; it++) begin
            s.delete();
            n0 = got_addr.size();
            e0 = err_cnt;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                b = 8'($urandom_range(0, 255));
                s.push_back(b == 8'hA5 ? 8'h5A : b);
            end
            n = $urandom_range(1, 4);
            s.push_back(8'hA5);
            s.push_back(8'(n));
            for (int z = 0; z < 3; z++) s.push_back(8'h00);
            for (int z = 0; z < 4 * n; z++) s.push_back(8'($urandom_range(0, 255)));
            model(s);
            send_seq(s);
            repeat (40) @(negedge clk);
            checks++;
            if (got_addr.size() - n0 !== exp_addr.size() || err_cnt - e0 !== 0)
                $display("FAIL random%0d_count got writes=%0d errs=%0d exp %0d/0", it, got_addr.size() - n0, err_cnt - e0, exp_addr.size());
            else passed++;
            for (int k = 0; k < exp_addr.size() && n0 + k < got_addr.size(); k++) begin
                checks++;
                if (got_addr[n0+k] !== exp_addr[k] || got_data[n0+k] !== exp_data[k])
                    $display("FAIL random%0d_write%0d got %h/%h exp %h/%h", it, k, got_addr[n0+k], got_data[n0+k], exp_addr[k], exp_data[k]);
                else passed++;
            end
            checks++;
            if (rise_cyc - fall_cyc !== (4 + 4 * n) * 100 + 16)
                $display("FAIL random%0d_window got %0d exp %0d", it, rise_cyc - fall_cyc, (4 + 4 * n) * 100 + 16);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_two_words;
        test_len_zero;
        test_timeout;
        test_framing;
        test_len_limit;
        test_reset_mid;
        test_random;
        checks++;
        if (we_double !== 1'b0) $display("FAIL we_single_cycle got double=%b exp 0", we_double);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
